mem_ctrl: RTL and testbench

- Sequences the single byte-wide RAM port: one bus address per cycle, 8-bit data each way, 1-cycle synchronous read latency.
- Shares that port between instruction fetch (IF) and the MEM stage.
- Takes the MEM-stage request fields (memaddr, memwr, memcnf, memsigned) produced by EX and carried down the pipeline.
- Splits B/H/W accesses into byte transfers, reassembles little-endian read data and sign/zero-extends it.
- Raises the stall that holds the pipeline until the access completes.

---
 rtl/mem_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_ctrl                                                         |
// | Brief    : Byte-wide RAM port sequencer shared by instruction fetch and the  |
// |            MEM stage; splits B/H/W accesses, reassembles and extends loads.  |
// |            Optional macro MEMCTRL_IO_WAIT_EN adds io_full_i write back-off.  |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module mem_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int IO_SEL_BIT = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    input  logic                  if_flush_i,
    output logic [31:0]           if_inst_o,
    output logic                  if_done_o,
    input  logic [1:0]            memcnf_i,
    input  logic                  memwr_i,
    input  logic                  memsigned_i,
    input  logic [ADDR_WIDTH-1:0] memaddr_i,
    input  logic [31:0]           memdata_i,
    output logic [31:0]           mem_rdata_o,
    output logic                  mem_done_o,
    output logic                  mem_stall_o,
    output logic [ADDR_WIDTH-1:0] ram_a_o,
    output logic [7:0]            ram_dout_o,
    input  logic [7:0]            ram_din_i,
    output logic                  ram_wr_o
`ifdef MEMCTRL_IO_WAIT_EN
    ,
    input  logic                  io_full_i
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    logic                  r_own_mem;
    logic [1:0]            r_cnf;
    logic                  r_signed;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [31:0]           r_wdata;
    logic [31:0]           r_buf;
    logic [2:0]            r_cnt;

    logic [2:0]            w_n;
    logic [2:0]            w_cnt_inc;
    logic [1:0]            w_cap_idx;
    logic [ADDR_WIDTH-1:0] w_next_a;
    logic [7:0]            w_next_byte;
    logic [31:0]           w_asm;
    logic [31:0]           w_ext;
    logic                  w_full;
    logic                  w_wait;
    logic                  w_wait_acc;

    always_comb begin
        case (r_cnf)
            2'd1:    w_n = 3'd1;
            2'd2:    w_n = 3'd2;
            default: w_n = 3'd4;
        endcase
    end

    assign w_cnt_inc   = r_cnt + 3'd1;
    assign w_cap_idx   = r_cnt[1:0] - 2'd1;
    assign w_next_a    = r_base + ADDR_WIDTH'(w_cnt_inc);
    assign w_next_byte = r_wdata[{w_cnt_inc[1:0], 3'b000} +: 8];

    // Final word: buffered bytes plus the last byte arriving this cycle.
    always_comb begin
        w_asm = r_buf;
        w_asm[{w_cap_idx, 3'b000} +: 8] = ram_din_i;
    end

    always_comb begin
        case (r_cnf)
            2'd1:    w_ext = {{24{r_signed & w_asm[7]}}, w_asm[7:0]};
            2'd2:    w_ext = {{16{r_signed & w_asm[15]}}, w_asm[15:0]};
            default: w_ext = w_asm;
        endcase
    end

`ifdef MEMCTRL_IO_WAIT_EN
    assign w_full = io_full_i;
`else
    assign w_full = 1'b0;
`endif

    assign w_wait     = (r_base[IO_SEL_BIT -: 2] == 2'b11) && w_full;
    assign w_wait_acc = (memaddr_i[IO_SEL_BIT -: 2] == 2'b11) && w_full;

    // Gated by rst so every output reads 0 while reset is held.
    assign mem_stall_o = rst && (memcnf_i != 2'd0) && !mem_done_o;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_own_mem   <= 1'b0;
            r_cnf       <= 2'd0;
            r_signed    <= 1'b0;
            r_base      <= '0;
            r_wdata     <= '0;
            r_buf       <= '0;
            r_cnt       <= 3'd0;
            ram_a_o     <= '0;
            ram_dout_o  <= '0;
            ram_wr_o    <= 1'b0;
            if_inst_o   <= '0;
            if_done_o   <= 1'b0;
            mem_rdata_o <= '0;
            mem_done_o  <= 1'b0;
        end else begin
            if_done_o  <= 1'b0;
            mem_done_o <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= 3'd0;
                    r_buf <= '0;
                    if (memcnf_i != 2'd0) begin
                        r_own_mem <= 1'b1;
                        r_cnf     <= memcnf_i;
                        r_signed  <= memsigned_i;
                        r_base    <= memaddr_i;
                        r_wdata   <= memdata_i;
                        ram_a_o   <= memaddr_i;
                        if (memwr_i) begin
                            r_state    <= S_WRITE;
                            ram_wr_o   <= !w_wait_acc;
                            ram_dout_o <= memdata_i[7:0];
                        end else begin
                            r_state <= S_READ;
                        end
                    end else if (if_req_i && !if_flush_i) begin
                        r_own_mem <= 1'b0;
                        r_cnf     <= 2'd3;
                        r_signed  <= 1'b0;
                        r_base    <= if_addr_i;
                        ram_a_o   <= if_addr_i;
                        r_state   <= S_READ;
                    end
                end
                S_READ: begin
                    if (!r_own_mem && if_flush_i) begin
                        r_state <= S_IDLE;
                    end else begin
                        if (r_cnt != 3'd0) begin
                            r_buf[{w_cap_idx, 3'b000} +: 8] <= ram_din_i;
                        end
                        if (r_cnt == w_n) begin
                            r_state <= S_DONE;
                            if (r_own_mem) begin
                                mem_rdata_o <= w_ext;
                                mem_done_o  <= 1'b1;
                            end else begin
                                if_inst_o <= w_ext;
                                if_done_o <= 1'b1;
                            end
                        end else begin
                            r_cnt <= w_cnt_inc;
                            if (w_cnt_inc != w_n) begin
                                ram_a_o <= w_next_a;
                            end
                        end
                    end
                end
                S_WRITE: begin
                    // ram_wr_o low means the current byte is still pending.
                    if (ram_wr_o) begin
                        if (w_cnt_inc == w_n) begin
                            ram_wr_o   <= 1'b0;
                            r_state    <= S_DONE;
                            mem_done_o <= 1'b1;
                        end else begin
                            r_cnt      <= w_cnt_inc;
                            ram_a_o    <= w_next_a;
                            ram_dout_o <= w_next_byte;
                            ram_wr_o   <= !w_wait;
                        end
                    end else begin
                        ram_wr_o <= !w_wait;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mem_ctrl                                                      |
// | Brief    : Scoreboard bench for mem_ctrl with a 1-cycle-latency ROM model.   |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_mem_ctrl;

    typedef struct {
        int          cyc;
        logic        is_if;
        logic        chk;
        logic [31:0] data;
    } done_t;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [7:0]  data;
    } bus_t;

    logic        clk;
    logic        rst;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_flush_i;
    logic [31:0] if_inst_o;
    logic        if_done_o;
    logic [1:0]  memcnf_i;
    logic        memwr_i;
    logic        memsigned_i;
    logic [31:0] memaddr_i;
    logic [31:0] memdata_i;
    logic [31:0] mem_rdata_o;
    logic        mem_done_o;
    logic        mem_stall_o;
    logic [31:0] ram_a_o;
    logic [7:0]  ram_dout_o;
    logic [7:0]  ram_din_i;
    logic        ram_wr_o;
`ifdef MEMCTRL_IO_WAIT_EN
    logic        io_full_i;
`endif

    int    cyc = 0;
    int    n_checks = 0;
    int    n_fail = 0;
    done_t done_q[$];
    bus_t  rd_q[$];
    bus_t  wr_q[$];

    mem_ctrl #(.ADDR_WIDTH(32), .IO_SEL_BIT(17)) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_flush_i  (if_flush_i),
        .if_inst_o   (if_inst_o),
        .if_done_o   (if_done_o),
        .memcnf_i    (memcnf_i),
        .memwr_i     (memwr_i),
        .memsigned_i (memsigned_i),
        .memaddr_i   (memaddr_i),
        .memdata_i   (memdata_i),
        .mem_rdata_o (mem_rdata_o),
        .mem_done_o  (mem_done_o),
        .mem_stall_o (mem_stall_o),
        .ram_a_o     (ram_a_o),
        .ram_dout_o  (ram_dout_o),
        .ram_din_i   (ram_din_i),
        .ram_wr_o    (ram_wr_o)
`ifdef MEMCTRL_IO_WAIT_EN
        ,
        .io_full_i   (io_full_i)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] rom(input logic [31:0] a);
        case (a)
            32'h0000_0100: rom = 8'h11;
            32'h0000_0101: rom = 8'h22;
            32'h0000_0102: rom = 8'h33;
            32'h0000_0103: rom = 8'h84;
            32'h0000_0200: rom = 8'h80;
            32'h0000_0201: rom = 8'h7F;
            32'h0000_0300: rom = 8'h34;
            32'h0000_0301: rom = 8'h92;
            32'h0000_0500: rom = 8'h13;
            32'h0000_0501: rom = 8'h05;
            32'h0000_0502: rom = 8'hA0;
            32'h0000_0503: rom = 8'h00;
            32'h0000_0504: rom = 8'h93;
            32'h0000_0505: rom = 8'h86;
            32'h0000_0506: rom = 8'hF6;
            32'h0000_0507: rom = 8'hFF;
            32'h0000_0700: rom = 8'h78;
            32'h0000_0701: rom = 8'h56;
            32'h0000_0702: rom = 8'h34;
            32'h0000_0703: rom = 8'h12;
            32'hFFFF_FFFE: rom = 8'hAA;
            32'hFFFF_FFFF: rom = 8'hBB;
            32'h0000_0000: rom = 8'hCC;
            32'h0000_0001: rom = 8'hDD;
            default:       rom = 8'h00;
        endcase
    endfunction

    // Synchronous RAM read port: data for last cycle's address.
    always @(posedge clk) ram_din_i <= rom(ram_a_o);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_reads(input logic is_if, input logic [31:0] base, input int n,
                              input int a, input logic [31:0] exp);
        bus_t  b;
        done_t d;
        for (int k = 0; k < n; k++) begin
            b.cyc = a + k; b.addr = base + 32'(k); b.data = 8'h00;
            rd_q.push_back(b);
        end
        d.cyc = a + n + 1; d.is_if = is_if; d.chk = 1'b1; d.data = exp;
        done_q.push_back(d);
    endtask

    task automatic push_writes(input logic [31:0] base, input int n, input logic [31:0] data,
                               input int a);
        bus_t  b;
        done_t d;
        for (int k = 0; k < n; k++) begin
            b.cyc = a + k; b.addr = base + 32'(k); b.data = data[8*k +: 8];
            wr_q.push_back(b);
        end
        d.cyc = a + n; d.is_if = 1'b0; d.chk = 1'b0; d.data = 32'h0;
        done_q.push_back(d);
    endtask

    task automatic wait_mem(input int exp_done);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            chk("mem_stall", {31'b0, mem_stall_o}, (cyc == exp_done) ? 32'd0 : 32'd1);
            if (mem_done_o) seen = 1'b1;
        end
        if (!seen) begin
            n_checks++; n_fail++;
            $display("FAIL mem_done_timeout: actual none required pulse");
        end
        tick();
        memcnf_i = 2'd0; memwr_i = 1'b0; memsigned_i = 1'b0;
    endtask

    task automatic wait_if();
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (if_done_o) seen = 1'b1;
        end
        if (!seen) begin
            n_checks++; n_fail++;
            $display("FAIL if_done_timeout: actual none required pulse");
        end
        tick();
        if_req_i = 1'b0;
    endtask

    // Issues a MEM request in the current (idle) cycle and waits for its completion.
    task automatic mem_op(input logic [1:0] cnf, input logic wr, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] data,
                          input logic [31:0] exp);
        int a;
        int n;
        n = (cnf == 2'd1) ? 1 : (cnf == 2'd2) ? 2 : 4;
        memcnf_i = cnf; memwr_i = wr; memsigned_i = sgn; memaddr_i = addr; memdata_i = data;
        a = cyc + 1;
        if (wr) begin
            push_writes(addr, n, data, a);
            wait_mem(a + n);
        end else begin
            push_reads(1'b0, addr, n, a, exp);
            wait_mem(a + n + 1);
        end
    endtask

    // Monitor: compares every done pulse and bus transaction against the queues.
    initial begin
        done_t d;
        bus_t  b;
        forever begin
            @(negedge clk);
            if (mem_done_o || if_done_o) begin
                if (done_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL done_unexpected: actual mem=%0b if=%0b required none",
                             mem_done_o, if_done_o);
                end else begin
                    d = done_q.pop_front();
                    chk("done_owner_if", {31'b0, if_done_o}, {31'b0, d.is_if});
                    chk("done_cycle", cyc, d.cyc);
                    if (d.chk) chk("done_data", d.is_if ? if_inst_o : mem_rdata_o, d.data);
                end
            end
            if (ram_wr_o) begin
                if (wr_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL write_unexpected: actual addr %0h data %0h required none",
                             ram_a_o, ram_dout_o);
                end else begin
                    b = wr_q.pop_front();
                    chk("wr_addr", ram_a_o, b.addr);
                    chk("wr_data", {24'b0, ram_dout_o}, {24'b0, b.data});
                    chk("wr_cycle", cyc, b.cyc);
                end
            end
            if (rd_q.size() != 0 && rd_q[0].cyc == cyc) begin
                b = rd_q.pop_front();
                chk("rd_addr", ram_a_o, b.addr);
                chk("rd_wr_low", {31'b0, ram_wr_o}, 32'd0);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_ram_wr"},    {31'b0, ram_wr_o},    32'd0);
        chk({tag, "_ram_a"},     ram_a_o,              32'd0);
        chk({tag, "_ram_dout"},  {24'b0, ram_dout_o},  32'd0);
        chk({tag, "_if_inst"},   if_inst_o,            32'd0);
        chk({tag, "_if_done"},   {31'b0, if_done_o},   32'd0);
        chk({tag, "_mem_rdata"}, mem_rdata_o,          32'd0);
        chk({tag, "_mem_done"},  {31'b0, mem_done_o},  32'd0);
        chk({tag, "_mem_stall"}, {31'b0, mem_stall_o}, 32'd0);
    endtask

    initial begin
        int a;
        rst = 1'b0; if_req_i = 1'b0; if_addr_i = '0; if_flush_i = 1'b0;
        memcnf_i = 2'd3; memwr_i = 1'b0; memsigned_i = 1'b0; memaddr_i = '0; memdata_i = '0;
`ifdef MEMCTRL_IO_WAIT_EN
        io_full_i = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        memcnf_i = 2'd0;
        tick();
        rst = 1'b1;
        repeat (2) tick();

        // Loads of each width and signedness, plus address wrap.
        mem_op(2'd3, 1'b0, 1'b0, 32'h0000_0100, 32'h0, 32'h8433_2211);
        mem_op(2'd1, 1'b0, 1'b1, 32'h0000_0200, 32'h0, 32'hFFFF_FF80);
        mem_op(2'd1, 1'b0, 1'b0, 32'h0000_0200, 32'h0, 32'h0000_0080);
        mem_op(2'd1, 1'b0, 1'b1, 32'h0000_0201, 32'h0, 32'h0000_007F);
        mem_op(2'd2, 1'b0, 1'b1, 32'h0000_0300, 32'h0, 32'hFFFF_9234);
        mem_op(2'd2, 1'b0, 1'b0, 32'h0000_0300, 32'h0, 32'h0000_9234);
        mem_op(2'd3, 1'b0, 1'b1, 32'hFFFF_FFFE, 32'h0, 32'hDDCC_BBAA);

        // Stores.
        mem_op(2'd2, 1'b1, 1'b0, 32'h0000_0400, 32'hDEAD_BEEF, 32'h0);
        mem_op(2'd3, 1'b1, 1'b0, 32'h0000_0410, 32'h0102_0304, 32'h0);
        mem_op(2'd1, 1'b1, 1'b0, 32'h0000_0420, 32'h0000_00A5, 32'h0);

        // Plain fetch.
        if_req_i = 1'b1; if_addr_i = 32'h0000_0500;
        a = cyc + 1;
        push_reads(1'b1, 32'h0000_0500, 4, a, 32'h00A0_0513);
        wait_if();

        // Simultaneous fetch and LW: MEM first, fetch after the DONE turnaround.
        if_req_i = 1'b1; if_addr_i = 32'h0000_0504;
        memcnf_i = 2'd3; memwr_i = 1'b0; memsigned_i = 1'b0; memaddr_i = 32'h0000_0100;
        a = cyc + 1;
        push_reads(1'b0, 32'h0000_0100, 4, a, 32'h8433_2211);
        push_reads(1'b1, 32'h0000_0504, 4, a + 7, 32'hFFF6_8693);
        wait_mem(a + 5);
        wait_if();

        // Fetch flushed in its second cycle, then an LW straight after.
        if_req_i = 1'b1; if_addr_i = 32'h0000_0500;
        a = cyc + 1;
        push_reads(1'b1, 32'h0000_0500, 2, a, 32'h0);
        void'(done_q.pop_back());
        tick();
        tick();
        if_flush_i = 1'b1;
        tick();
        if_flush_i = 1'b0; if_req_i = 1'b0;
        mem_op(2'd3, 1'b0, 1'b0, 32'h0000_0700, 32'h0, 32'h1234_5678);

        // Reset in the middle of a SW: outputs clear at once, no done pulse.
        memcnf_i = 2'd3; memwr_i = 1'b1; memaddr_i = 32'h0000_0600; memdata_i = 32'hCAFE_F00D;
        a = cyc + 1;
        push_writes(32'h0000_0600, 2, 32'hCAFE_F00D, a);
        void'(done_q.pop_back());
        repeat (3) tick();
        rst = 1'b0;
        #1;
        check_all_zero("midrst");
        memcnf_i = 2'd0; memwr_i = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        repeat (3) tick();

`ifdef MEMCTRL_IO_WAIT_EN
        // IO-region store held off for three cycles by io_full_i.
        io_full_i = 1'b1;
        memcnf_i = 2'd1; memwr_i = 1'b1; memaddr_i = 32'h0003_0000; memdata_i = 32'h0000_005A;
        a = cyc + 1;
        push_writes(32'h0003_0000, 1, 32'h0000_005A, a + 3);
        void'(done_q.pop_back());
        begin
            done_t d;
            d.cyc = a + 4; d.is_if = 1'b0; d.chk = 1'b0; d.data = 32'h0;
            done_q.push_back(d);
        end
        repeat (3) tick();
        io_full_i = 1'b0;
        wait_mem(a + 4);
`endif

        repeat (4) tick();
        chk("done_q_empty", 32'(done_q.size()), 32'd0);
        chk("rd_q_empty",   32'(rd_q.size()),   32'd0);
        chk("wr_q_empty",   32'(wr_q.size()),   32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
